// File: rtl/coleco_bus_mapper.sv
// coleco_bus_mapper
//   Z80 bus glue for a ColecoVision-class console: combinational chip-select
//   decode plus registered cartridge bank windows, SGM RAM/BIOS overlay
//   control, AY-3-8910 bus-control strobes and an AY I/O wait-state generator.
//
// Ports
//   clk, RESET                       clock, synchronous active-high reset
//   A[15:0], D[7:0]                  Z80 address / data (D sampled on I/O writes)
//   MREQn IORQn RFSHn M1n RDn WRn    Z80 bus strobes
//   BIOS_CSn RAM_CSn SGM_CSn CART_CSn  active-low chip selects
//   CART_A                           cartridge ROM address {bank, window offset}
//   AY_BDIR, AY_BC1                  AY bus control
//   WAITn                            Z80 wait request
//   DIS_MEM                          BIOS overlay active
//
// Optional feature macro: MEGACART_EN
//   When defined, a memory read of 0xFFC0-0xFFFF loads the last window's
//   bank register from A[5:0] (once per read strobe).

module coleco_bus_mapper #(
  parameter int         NUM_WIN   = 4,
  parameter int         BANK_BITS = 6,
  parameter logic [7:0] BANK_PORT = 8'h40,
  parameter logic [7:0] AY_PORT   = 8'h50,
  parameter logic [7:0] SGM_PORT  = 8'h53,
  parameter logic [7:0] BIOS_PORT = 8'h7F,
  parameter int         AY_WAIT   = 2
) (
  input  logic                                      clk,
  input  logic                                      RESET,
  input  logic [15:0]                               A,
  input  logic [7:0]                                D,
  input  logic                                      MREQn,
  input  logic                                      IORQn,
  input  logic                                      RFSHn,
  input  logic                                      M1n,
  input  logic                                      RDn,
  input  logic                                      WRn,
  output logic                                      BIOS_CSn,
  output logic                                      RAM_CSn,
  output logic                                      SGM_CSn,
  output logic                                      CART_CSn,
  output logic [BANK_BITS+15-$clog2(NUM_WIN)-1:0]   CART_A,
  output logic                                      AY_BDIR,
  output logic                                      AY_BC1,
  output logic                                      WAITn,
  output logic                                      DIS_MEM
);

  localparam int WIN_BITS = $clog2(NUM_WIN);
  localparam int OFF_BITS = 15 - WIN_BITS;
  // Counter is at least 1 bit wide so AY_WAIT=0 still elaborates; it then
  // only ever loads 0 and WAITn stays high.
  localparam int CW       = (AY_WAIT < 1) ? 1 : $clog2(AY_WAIT + 1);

  logic                               mem, io, io_wr, io_any;
  logic                               io_wr_q, io_any_q;
  logic                               wr_edge, ay_edge, ay_port_hit;
  logic                               sgm_en, bios_off;
  logic [NUM_WIN-1:0][BANK_BITS-1:0]  bank;
  logic [BANK_BITS-1:0]               cur_bank;
  logic [CW-1:0]                      cnt;
  logic [7:0]                         port;
  logic                               unused;

  assign mem     = !MREQn && RFSHn;
  assign io      = !IORQn && M1n;   // M1n gate keeps interrupt acknowledge out
  assign io_wr   = io && !WRn;
  assign io_any  = io && (!RDn || !WRn);
  assign port    = A[7:0];
  assign wr_edge = io_wr && !io_wr_q;

  assign ay_port_hit = (port == AY_PORT) || (port == 8'(AY_PORT + 1)) ||
                       (port == 8'(AY_PORT + 2));
  assign ay_edge     = io_any && !io_any_q && ay_port_hit;

  assign unused  = ^D;

`ifdef MEGACART_EN
  logic                 mem_rd, mem_rd_q, mc_edge;
  logic [BANK_BITS-1:0] mc_val;

  assign mem_rd  = mem && !RDn;
  assign mc_edge = mem_rd && !mem_rd_q && (A[15:6] == 10'h3FF);
  assign mc_val  = BANK_BITS'(A[5:0]);

  always_ff @(posedge clk) begin
    if (RESET) mem_rd_q <= 1'b0;
    else       mem_rd_q <= mem_rd;
  end
`endif

  // ---------------------------------------------------------------- state
  always_ff @(posedge clk) begin
    if (RESET) begin
      io_wr_q  <= 1'b0;
      io_any_q <= 1'b0;
      sgm_en   <= 1'b0;
      bios_off <= 1'b0;
      cnt      <= '0;
      for (int i = 0; i < NUM_WIN; i++) bank[i] <= BANK_BITS'(i);
    end else begin
      io_wr_q  <= io_wr;
      io_any_q <= io_any;
      if (wr_edge && port == SGM_PORT)  sgm_en   <= D[0];
      if (wr_edge && port == BIOS_PORT) bios_off <= !D[1];
      for (int i = 0; i < NUM_WIN; i++) begin
        if (wr_edge && port == 8'(BANK_PORT + i))
          bank[i] <= D[BANK_BITS-1:0];
`ifdef MEGACART_EN
        else if (i == NUM_WIN - 1 && mc_edge)
          bank[i] <= mc_val;
`endif
      end
      // Triggers arriving while a count is running are dropped.
      if (cnt != '0)    cnt <= cnt - 1'b1;
      else if (ay_edge) cnt <= CW'(AY_WAIT);
    end
  end

  assign WAITn   = RESET || (cnt == '0);
  assign DIS_MEM = bios_off;

  // ---------------------------------------------------------- cart address
  generate
    if (WIN_BITS == 0) begin : g_one_win
      assign cur_bank = bank[0];
    end else begin : g_multi_win
      assign cur_bank = bank[A[14 -: WIN_BITS]];
    end
  endgenerate

  assign CART_A = {cur_bank, A[OFF_BITS-1:0]};

  // -------------------------------------------------------- chip selects
  always_comb begin
    BIOS_CSn = 1'b1;
    RAM_CSn  = 1'b1;
    SGM_CSn  = 1'b1;
    CART_CSn = 1'b1;
    if (!RESET && mem) begin
      case (A[15:13])
        3'b000:         if (bios_off) SGM_CSn = 1'b0; else BIOS_CSn = 1'b0;
        3'b001, 3'b010: if (sgm_en)   SGM_CSn = 1'b0;
        3'b011:         if (sgm_en)   SGM_CSn = 1'b0; else RAM_CSn = 1'b0;
        default:        CART_CSn = 1'b0;
      endcase
    end
  end

  // ----------------------------------------------------------- AY control
  always_comb begin
    AY_BDIR = 1'b0;
    AY_BC1  = 1'b0;
    if (!RESET && io) begin
      if (port == AY_PORT && !WRn) begin
        AY_BDIR = 1'b1;
        AY_BC1  = 1'b1;
      end else if (port == 8'(AY_PORT + 1) && !WRn) begin
        AY_BDIR = 1'b1;
      end else if (port == 8'(AY_PORT + 2) && !RDn) begin
        AY_BC1  = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_coleco_bus_mapper.sv
// Directed bench for coleco_bus_mapper (default parameters: 4 windows,
// 6-bit banks, AY_WAIT=2). Inputs change 1 ns after the rising edge;
// combinational outputs are sampled at the falling edge, registered
// effects 1 ns after the rising edge.

module tb_coleco_bus_mapper;

  logic        clk = 1'b0;
  logic        RESET;
  logic [15:0] A;
  logic [7:0]  D;
  logic        MREQn, IORQn, RFSHn, M1n, RDn, WRn;
  logic        BIOS_CSn, RAM_CSn, SGM_CSn, CART_CSn;
  logic [18:0] CART_A;
  logic        AY_BDIR, AY_BC1, WAITn, DIS_MEM;

  int total = 0;
  int fails = 0;

  coleco_bus_mapper dut (
    .clk(clk), .RESET(RESET), .A(A), .D(D),
    .MREQn(MREQn), .IORQn(IORQn), .RFSHn(RFSHn), .M1n(M1n), .RDn(RDn), .WRn(WRn),
    .BIOS_CSn(BIOS_CSn), .RAM_CSn(RAM_CSn), .SGM_CSn(SGM_CSn), .CART_CSn(CART_CSn),
    .CART_A(CART_A), .AY_BDIR(AY_BDIR), .AY_BC1(AY_BC1), .WAITn(WAITn),
    .DIS_MEM(DIS_MEM)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // cs vector order: {BIOS, RAM, SGM, CART}
  function automatic logic [3:0] cs();
    return {BIOS_CSn, RAM_CSn, SGM_CSn, CART_CSn};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    MREQn = 1'b1; IORQn = 1'b1; RFSHn = 1'b1; M1n = 1'b1; RDn = 1'b1; WRn = 1'b1;
  endtask

  // Start a memory read and stop at the falling edge for sampling.
  task automatic mrd(input logic [15:0] a);
    idle(); A = a; MREQn = 1'b0; RDn = 1'b0;
    @(negedge clk);
  endtask

  task automatic rel();
    step(); idle(); step();
  endtask

  task automatic iow(input logic [7:0] p, input logic [7:0] d);
    idle(); A = {8'h00, p}; D = d; IORQn = 1'b0; WRn = 1'b0;
    step(); idle(); step();
  endtask

  // AY access: strobe check mid-cycle, then WAITn low for two clocks.
  task automatic ay(input logic [7:0] p, input bit wr, input logic [1:0] exp, input string tag);
    idle(); A = {8'h00, p}; IORQn = 1'b0;
    if (wr) WRn = 1'b0; else RDn = 1'b0;
    @(negedge clk);
    chk({tag, "_ctl"}, {AY_BDIR, AY_BC1}, exp);
    chk({tag, "_w0"}, WAITn, 1'b1);
    step(); chk({tag, "_w1"}, WAITn, 1'b0);
    step(); chk({tag, "_w2"}, WAITn, 1'b0);
    step(); chk({tag, "_w3"}, WAITn, 1'b1);
    idle(); step();
  endtask

  initial begin
    idle(); A = 16'h0000; D = 8'h00; RESET = 1'b1;
    step(); step();

    // ---- outputs forced while in reset; writes during reset ignored
    mrd(16'h0000);
    chk("rst_cs", cs(), 4'b1111);
    chk("rst_wait", WAITn, 1'b1);
    rel();
    idle(); A = 16'h0041; D = 8'h3F; IORQn = 1'b0; WRn = 1'b0;
    step(); idle(); step();
    A = 16'h0050; IORQn = 1'b0; WRn = 1'b0;
    @(negedge clk);
    chk("rst_ay", {AY_BDIR, AY_BC1}, 2'b00);
    step(); idle(); RESET = 1'b0; step();

    // ---- base memory map
    chk("dis_mem0", DIS_MEM, 1'b0);
    chk("wait_idle", WAITn, 1'b1);
    mrd(16'h0000); chk("bios_cs", cs(), 4'b0111); rel();
    mrd(16'h6000); chk("ram_cs", cs(), 4'b1011); rel();
    mrd(16'h9000); chk("cart_cs", cs(), 4'b1110); chk("cart_a_9000", CART_A, 19'h01000); rel();
    mrd(16'hA000); chk("cart_a_bank1", CART_A, 19'h02000); rel();
    mrd(16'h2000); chk("hole_cs", cs(), 4'b1111); rel();
    mrd(16'hC123); chk("cart_a_c123", CART_A, 19'h04123); rel();

    // ---- held bank write: only the first clock of the strobe acts
    idle(); A = 16'h0042; D = 8'h2A; IORQn = 1'b0; WRn = 1'b0;
    step(); D = 8'h15;
    repeat (9) step();
    chk("wait_nonay", WAITn, 1'b1);
    idle(); step();
    mrd(16'hC123); chk("cart_a_bank2a", CART_A, 19'h54123); rel();

    // ---- SGM enable and BIOS overlay
    iow(8'h53, 8'h01);
    iow(8'h7F, 8'h00);
    chk("dis_mem1", DIS_MEM, 1'b1);
    mrd(16'h0100); chk("sgm_bios", cs(), 4'b1101); rel();
    mrd(16'h3000); chk("sgm_mid", cs(), 4'b1101); rel();
    mrd(16'h6000); chk("sgm_ram", cs(), 4'b1101); rel();

    // ---- AY strobes and wait states
    ay(8'h50, 1'b1, 2'b11, "ay_addr");
    ay(8'h51, 1'b1, 2'b10, "ay_wr");
    ay(8'h52, 1'b0, 2'b01, "ay_rd");
    idle(); A = 16'h0080; IORQn = 1'b0; WRn = 1'b0;
    @(negedge clk); chk("p80_ctl", {AY_BDIR, AY_BC1}, 2'b00);
    step(); chk("p80_w1", WAITn, 1'b1);
    step(); chk("p80_w2", WAITn, 1'b1);
    idle(); step();

    // ---- reset in the middle of a wait count, after bank/config writes
    iow(8'h40, 8'h11);
    mrd(16'h9000); chk("cart_a_bank0", CART_A, 19'h23000); rel();
    idle(); A = 16'h0050; IORQn = 1'b0; WRn = 1'b0;
    step(); chk("mid_wait", WAITn, 1'b0);
    RESET = 1'b1; idle(); step();
    chk("rst_wait_hi", WAITn, 1'b1);
    RESET = 1'b0; #1;
    chk("cnt_cleared", WAITn, 1'b1);
    chk("dis_mem_rst", DIS_MEM, 1'b0);
    step();
    mrd(16'h9000); chk("bank0_rst", CART_A, 19'h01000); rel();
    mrd(16'h3000); chk("sgm_off_rst", cs(), 4'b1111); rel();
    mrd(16'h0000); chk("bios_rst", cs(), 4'b0111); rel();

    // ---- interrupt acknowledge (M1n low) is not an I/O access
    idle(); A = 16'h0050; IORQn = 1'b0; M1n = 1'b0; WRn = 1'b0;
    @(negedge clk); chk("inta_ctl", {AY_BDIR, AY_BC1}, 2'b00);
    step(); chk("inta_wait", WAITn, 1'b1);
    idle(); step();

    // ---- megacart-style hotspot read
    mrd(16'hFFC5); rel();
    mrd(16'hE000);
`ifdef MEGACART_EN
    chk("mc_bank3", CART_A, 19'h0A000);
`else
    chk("mc_bank3", CART_A, 19'h06000);
`endif
    rel();

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/coleco_bus_mapper.md
Name: coleco_bus_mapper

Overview:
Parametrised next-generation Z80 bus glue for the ColecoVision-class console. It decodes memory and I/O strobes into chip selects, as its predecessor does. It adds registered state on top of that decode: cartridge bank windows, Super Game Module (SGM) RAM/BIOS overlay control, AY-3-8910 bus-control sequencing and an I/O wait-state generator. It sits between the Z80 bus and the ROM/RAM/AY devices on the game module.

Parameters:
NUM_WIN, 4, number of equal cartridge windows in 0x8000-0xFFFF; legal values are 1, 2, 4 and 8. Window size is 32K/NUM_WIN.
BANK_BITS, 6, width of each bank register.
BANK_PORT, 8'h40, I/O port of window 0's bank register; window i is at BANK_PORT+i.
AY_PORT, 8'h50, AY base port: +0 latches the register address, +1 writes data, +2 reads data.
SGM_PORT, 8'h53, bit0 of a write enables SGM RAM.
BIOS_PORT, 8'h7F, bit1 of a write equal to 0 overlays the BIOS with RAM.
AY_WAIT, 2, number of clk cycles WAITn is held low per AY access; 0 disables wait states.

Ports:
clk  in  1  CPU-rate system clock; all state updates on the rising edge
RESET  in  1  synchronous, active-high reset
A  in  16  Z80 address bus
D  in  8  Z80 data bus, sampled on I/O writes
MREQn, IORQn, RFSHn, M1n, RDn, WRn  in  1 each  Z80 bus strobes
BIOS_CSn  out  1  BIOS ROM select
RAM_CSn  out  1  base 1K RAM select
SGM_CSn  out  1  SGM 32K RAM select
CART_CSn  out  1  cartridge ROM select
CART_A  out  BANK_BITS+15-log2(NUM_WIN)  cartridge ROM address: {bank, window offset}
AY_BDIR, AY_BC1  out  1 each  AY bus control
WAITn  out  1  Z80 wait request
DIS_MEM  out  1  high when the BIOS overlay is active

Behaviour:
- mem = !MREQn && RFSHn. io = !IORQn && M1n, so interrupt acknowledge is never decoded.
- Chip-select decode is combinational from A, the strobes and the registered state. Zero added latency.
- While RESET=1 every CSn is 1, AY_BDIR=AY_BC1=0 and WAITn=1.
- Memory map when mem is true:
  - 0x0000-0x1FFF: BIOS_CSn=0, or SGM_CSn=0 if bios_off.
  - 0x2000-0x5FFF: SGM_CSn=0 if sgm_en; otherwise no select.
  - 0x6000-0x7FFF: SGM_CSn=0 if sgm_en; otherwise RAM_CSn=0 (1K mirrored).
  - 0x8000-0xFFFF: CART_CSn=0.
- Window index w = A[14:15-log2(NUM_WIN)]. CART_A = {bank[w], A[14-log2(NUM_WIN):0]}. CART_A is driven regardless of CSn.
- Registered state and reset values:
  - bank[i] = i mod 2^BANK_BITS (linear mapping).
  - sgm_en = 0, bios_off = 0.
  - wait counter = 0.
  - io_wr_q = 0, io_any_q = 0.
- Write detection:
  - io_wr = io && !WRn. io_wr_q is io_wr delayed one clk.
  - A write acts exactly once per strobe, on the clk where io_wr && !io_wr_q.
  - The new value is visible from the next clk.
- Write decode uses A[7:0] only:
  - BANK_PORT+i for i < NUM_WIN: bank[i] <= D[BANK_BITS-1:0]. Ports at or beyond BANK_PORT+NUM_WIN are ignored.
  - SGM_PORT: sgm_en <= D[0].
  - BIOS_PORT: bios_off <= !D[1].
  - DIS_MEM = bios_off.
- AY control (combinational, requires io):
  - A[7:0]=AY_PORT with !WRn: BDIR=1, BC1=1.
  - AY_PORT+1 with !WRn: BDIR=1, BC1=0.
  - AY_PORT+2 with !RDn: BDIR=0, BC1=1.
  - Otherwise both are 0.
- Wait generator:
  - Trigger: the first clk of any io strobe (io_any = io && (!RDn || !WRn), rising edge via io_any_q) whose A[7:0] is in AY_PORT..AY_PORT+2.
  - From the following clk, WAITn=0 for exactly AY_WAIT clks, then 1.
  - New triggers while counting are ignored.
  - AY_WAIT=0: WAITn is constantly 1.
- Reset mid-operation: RESET=1 clears the counter (WAITn=1 next clk), restores all banks and config, and discards any in-progress strobe edge.
- Simultaneous events: RESET has priority over an I/O write on the same clk.

Optional Feature:
MEGACART_EN
- When defined: an additional bank-switch trigger. Any memory read (mem && !RDn) to 0xFFC0-0xFFFF sets bank[NUM_WIN-1] <= A[5:0], zero-extended or truncated to BANK_BITS.
  - It is edge-detected once per strobe, like I/O writes.
  - An I/O write to bank[NUM_WIN-1] on the same clk takes priority.
- When undefined: banks change only via I/O writes, and reads never alter state.

Test Plan:
- Reset, then read 0x0000, 0x6000, 0x9000 -> respectively BIOS_CSn=0; RAM_CSn=0; CART_CSn=0 with CART_A=0x01000 (NUM_WIN=4, bank[0]=0).
- I/O write port 0x42, D=0x2A, then read 0xC123 -> CART_CSn=0, CART_A={6'h2A,13'h0123}. Holding WRn low for 10 clks performs exactly one update.
- Write 0x53 D=0x01, then 0x7F D=0x00 -> read 0x0100 gives SGM_CSn=0 and BIOS_CSn=1; read 0x3000 gives SGM_CSn=0; DIS_MEM=1.
- I/O write port 0x50, then 0x51, then read 0x52 -> BDIR/BC1 = 11, 10, 01 during the strobes. WAITn is low for exactly 2 clks starting 1 clk after each strobe's first sampled clk. Port 0x80 gives no wait.
- Assert RESET during a wait count and after bank/SGM writes -> WAITn=1, DIS_MEM=0 and bank[i]=i on the next clk. An M1n=0 IORQ cycle at 0x50 produces no AY strobe.
- With MEGACART_EN: read 0xFFC5 -> bank[3]=5, and a subsequent read at 0xE000 gives CART_A={6'h05,13'h0000}. Without the macro, bank[3] stays 3.
